// File: rtl/scaler_channel_scheduler_if.sv
// scaler_channel_scheduler_if: bundles the raw-sample, scaler and result signals of the channel scheduler.
//   slave  : scheduler side (takes raw samples, en, clr_overrun and scaler_out; drives everything else)
//   master : capture/display/scaler side (the mirror image)
interface scaler_channel_scheduler_if #(parameter int N_CH = 13);
  logic                 en;
  logic [N_CH-1:0]      raw_valid;
  logic [N_CH*12-1:0]   raw_data;
  logic [11:0]          scaler_in;
  logic [11:0]          scaler_out;
  logic                 result_valid;
  logic [3:0]           result_ch;
  logic [11:0]          result_data;
  logic [N_CH*12-1:0]   mv_flat;
  logic [N_CH-1:0]      overrun;
  logic                 clr_overrun;
  logic                 busy;
  modport slave (
    input  en, raw_valid, raw_data, scaler_out, clr_overrun,
    output scaler_in, result_valid, result_ch, result_data, mv_flat, overrun, busy
  );
  modport master (
    output en, raw_valid, raw_data, scaler_out, clr_overrun,
    input  scaler_in, result_valid, result_ch, result_data, mv_flat, overrun, busy
  );
endinterface

// File: rtl/scaler_channel_scheduler.sv
// scaler_channel_scheduler: round-robin sharing of one fixed-latency voltage scaler among N_CH ADC channels.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   s       : slave modport carrying raw samples in, scaler operand/result, tagged results,
//             per-channel latest values, sticky overrun flags and busy
module scaler_channel_scheduler #(
  parameter int N_CH    = 13,
  parameter int LATENCY = 4
) (
  input logic                        i_clk,
  input logic                        i_rst_n,
  scaler_channel_scheduler_if.slave  s
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             r_state, w_state_nxt;
  logic [11:0]        r_hold [N_CH];
  logic [N_CH-1:0]    r_pend, w_pend_nxt;
  logic [N_CH-1:0]    r_ovr, w_ovr_nxt;
  logic [3:0]         r_ptr, w_grant, w_idx;
  logic [4:0]         w_sum;
  logic               w_issue, w_any, w_hit;
  logic [11:0]        r_scaler_in;
  logic [LATENCY:0]   r_tag_v;
  logic [3:0]         r_tag_ch [LATENCY+1];
  logic               r_result_valid;
  logic [3:0]         r_result_ch;
  logic [11:0]        r_result_data;
  logic [N_CH*12-1:0] r_mv;
  assign w_any = |r_pend;
  // Walk from farthest to nearest so the first pending channel after ptr wins.
  always_comb begin
    w_grant = r_ptr;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_sum = 5'(r_ptr) + 5'(k);
      w_idx = 4'((w_sum >= 5'(N_CH)) ? w_sum - 5'(N_CH) : w_sum);
      if (r_pend[w_idx]) w_grant = w_idx;
    end
  end
  // The state is re-decided every edge; the edge that enters or stays in RUN is an issue edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s.en && w_any) w_state_nxt = RUN;
      RUN:     if (!(s.en && w_any)) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    w_issue = (w_state_nxt == RUN);
  end
  // A channel issued at the same edge it is re-strobed keeps pending without an overrun.
  always_comb begin
    w_pend_nxt = '0;
    w_ovr_nxt  = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_hit         = w_issue && (w_grant == 4'(i));
      w_pend_nxt[i] = s.raw_valid[i] | (r_pend[i] & ~w_hit);
      w_ovr_nxt[i]  = (s.raw_valid[i] & r_pend[i] & ~w_hit) | (r_ovr[i] & ~s.clr_overrun);
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= IDLE;
      r_pend         <= '0;
      r_ovr          <= '0;
      r_ptr          <= 4'(N_CH - 1);
      r_scaler_in    <= '0;
      r_tag_v        <= '0;
      r_result_valid <= 1'b0;
      r_result_ch    <= '0;
      r_result_data  <= '0;
      r_mv           <= '0;
      for (int i = 0; i < N_CH; i++) r_hold[i] <= '0;
      for (int k = 0; k <= LATENCY; k++) r_tag_ch[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_ovr   <= w_ovr_nxt;
      for (int i = 0; i < N_CH; i++)
        if (s.raw_valid[i]) r_hold[i] <= s.raw_data[12*i +: 12];
      if (w_issue) begin
        r_scaler_in <= r_hold[w_grant];
        r_ptr       <= w_grant;
      end
      r_tag_v     <= {r_tag_v[LATENCY-1:0], w_issue};
      r_tag_ch[0] <= w_grant;
      for (int k = 1; k <= LATENCY; k++) r_tag_ch[k] <= r_tag_ch[k-1];
      r_result_valid <= r_tag_v[LATENCY];
      if (r_tag_v[LATENCY]) begin
        r_result_ch                         <= r_tag_ch[LATENCY];
        r_result_data                       <= s.scaler_out;
        r_mv[12*r_tag_ch[LATENCY] +: 12]    <= s.scaler_out;
      end
    end
  end
  assign s.scaler_in    = r_scaler_in;
  assign s.result_valid = r_result_valid;
  assign s.result_ch    = r_result_ch;
  assign s.result_data  = r_result_data;
  assign s.mv_flat      = r_mv;
  assign s.overrun      = r_ovr;
  assign s.busy         = w_any | (|r_tag_v);
endmodule

// File: tb/tb_scaler_channel_scheduler.sv
// tb_scaler_channel_scheduler: directed bench with an event-queue reference model and a 4-stage scaler stand-in.
module tb_scaler_channel_scheduler;
  localparam int N   = 13;
  localparam int LAT = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  scaler_channel_scheduler_if #(.N_CH(N)) s ();
  scaler_channel_scheduler #(.N_CH(N), .LATENCY(LAT)) dut (.i_clk(clk), .i_rst_n(rst_n), .s(s));
  function automatic int scale(input int v);
    return (v * 25177) / 31250;
  endfunction
  logic [11:0] sp [LAT];
  initial for (int k = 0; k < LAT; k++) sp[k] = '0;
  always @(posedge clk) begin
    sp[0] <= 12'(scale(int'(s.scaler_in)));
    for (int k = 1; k < LAT; k++) sp[k] <= sp[k-1];
  end
  assign s.scaler_out = sp[LAT-1];
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {int at; int ch; int val;} ev_t;
  ev_t q[$];
  int  n = 0;
  bit  m_pend [N];
  int  m_hold [N];
  bit  m_ovr  [N];
  int  m_mv   [N];
  int  m_ptr, m_si, m_rch, m_rdata, c;
  bit  m_rv, m_busy, any;
  logic [N*12-1:0] e_mv;
  logic [N-1:0]    e_ovr;
  always @(posedge clk) begin
    n++;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_hold[i] = 0; m_ovr[i] = 0; m_mv[i] = 0;
      end
      m_ptr = N - 1; m_si = 0; m_rv = 0; m_rch = 0; m_rdata = 0;
      q.delete();
    end else begin
      any = 0;
      for (int i = 0; i < N; i++) any |= m_pend[i];
      if (s.en && any) begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (m_pend[c]) break;
        end
        m_si = m_hold[c];
        q.push_back('{n + LAT + 1, c, scale(m_hold[c])});
        m_pend[c] = 0;
        m_ptr = c;
      end
      if (s.clr_overrun) for (int i = 0; i < N; i++) m_ovr[i] = 0;
      for (int i = 0; i < N; i++)
        if (s.raw_valid[i]) begin
          if (m_pend[i]) m_ovr[i] = 1;
          m_hold[i] = int'(s.raw_data[12*i +: 12]);
          m_pend[i] = 1;
        end
      m_rv = 0;
      if (q.size() > 0 && q[0].at == n) begin
        m_rv = 1; m_rch = q[0].ch; m_rdata = q[0].val; m_mv[q[0].ch] = q[0].val;
        void'(q.pop_front());
      end
    end
    m_busy = q.size() > 0;
    for (int i = 0; i < N; i++) begin
      m_busy |= m_pend[i];
      e_mv[12*i +: 12] = 12'(m_mv[i]);
      e_ovr[i] = m_ovr[i];
    end
    #1;
    chk("scaler_in", s.scaler_in, m_si);
    chk("result_valid", s.result_valid, m_rv);
    chk("result_ch", s.result_ch, m_rch);
    chk("result_data", s.result_data, m_rdata);
    chk("mv_flat", s.mv_flat, e_mv);
    chk("overrun", s.overrun, e_ovr);
    chk("busy", s.busy, m_busy);
  end
  task automatic tick();
    @(negedge clk);
    s.raw_valid = '0;
    s.clr_overrun = 1'b0;
  endtask
  task automatic set_raw(input int ch, input int val);
    s.raw_valid[ch] = 1'b1;
    s.raw_data[12*ch +: 12] = 12'(val);
  endtask
  task automatic wait_rv(output int lat);
    lat = 0;
    while (!s.result_valid && lat < 30) begin
      tick();
      lat++;
    end
    if (!s.result_valid) begin
      errors++;
      $display("FAIL wait_rv: got timeout expected result_valid");
    end
  endtask
  int lat, cnt;
  initial begin
    s.en = 1'b0; s.raw_valid = '0; s.raw_data = '0; s.clr_overrun = 1'b0;
    repeat (3) tick();
    chk("rst_scaler_in", s.scaler_in, 0);
    chk("rst_result_valid", s.result_valid, 0);
    chk("rst_result_ch", s.result_ch, 0);
    chk("rst_result_data", s.result_data, 0);
    chk("rst_mv_flat", s.mv_flat, 0);
    chk("rst_overrun", s.overrun, 0);
    chk("rst_busy", s.busy, 0);
    rst_n = 1'b1; s.en = 1'b1;
    tick();
    for (int i = 0; i < N; i++) set_raw(i, 1000);
    tick();
    wait_rv(lat);
    chk("sweep_latency", lat, 6);
    for (int i = 0; i < N; i++) begin
      chk("sweep_valid", s.result_valid, 1);
      chk("sweep_ch", s.result_ch, i);
      chk("sweep_data", s.result_data, 805);
      tick();
    end
    chk("sweep_end_valid", s.result_valid, 0);
    chk("sweep_end_busy", s.busy, 0);
    repeat (2) tick();
    set_raw(0, 4095);
    tick();
    wait_rv(lat);
    chk("ch0_latency", lat, 6);
    chk("ch0_ch", s.result_ch, 0);
    chk("ch0_data", s.result_data, 3299);
    chk("ch0_mv", s.mv_flat[11:0], 3299);
    tick();
    chk("ch0_single", s.result_valid, 0);
    repeat (2) tick();
    s.en = 1'b0;
    set_raw(5, 1000);
    tick();
    set_raw(5, 2048);
    tick();
    chk("ovr5_set", s.overrun[5], 1);
    s.en = 1'b1;
    wait_rv(lat);
    chk("ovr5_ch", s.result_ch, 5);
    chk("ovr5_data", s.result_data, 1649);
    cnt = 0;
    repeat (8) begin
      tick();
      if (s.result_valid) cnt++;
    end
    chk("ovr5_single", cnt, 0);
    chk("ovr5_sticky", s.overrun[5], 1);
    s.clr_overrun = 1'b1;
    tick();
    chk("ovr5_clr", s.overrun[5], 0);
    s.en = 1'b0;
    set_raw(3, 1000);
    tick();
    s.en = 1'b1;
    set_raw(3, 2048);
    tick();
    wait_rv(lat);
    chk("same_edge_first", s.result_data, 805);
    tick();
    chk("same_edge_second_v", s.result_valid, 1);
    chk("same_edge_second", s.result_data, 1649);
    chk("same_edge_ovr", s.overrun[3], 0);
    repeat (2) tick();
    set_raw(2, 500);
    tick();
    wait_rv(lat);
    chk("rr_setup_ch", s.result_ch, 2);
    repeat (2) tick();
    s.en = 1'b0;
    set_raw(2, 100);
    set_raw(7, 200);
    tick();
    s.en = 1'b1;
    wait_rv(lat);
    chk("rr_first_ch", s.result_ch, 7);
    chk("rr_first_data", s.result_data, 161);
    tick();
    chk("rr_second_v", s.result_valid, 1);
    chk("rr_second_ch", s.result_ch, 2);
    chk("rr_second_data", s.result_data, 80);
    repeat (3) tick();
    set_raw(4, 3000);
    tick();
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("mid_rst_scaler_in", s.scaler_in, 0);
    chk("mid_rst_result_data", s.result_data, 0);
    chk("mid_rst_mv_flat", s.mv_flat, 0);
    chk("mid_rst_busy", s.busy, 0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (10) begin
      tick();
      if (s.result_valid) cnt++;
    end
    chk("mid_rst_no_result", cnt, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
